// File: rtl/bit_serial_adder.sv
// Bit-serial adder: one full-adder cell reused over WIDTH clocks, LSB first,
// with valid/ready handshakes on the operand and result sides.
module bit_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    count_q, count_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             out_valid_q, out_valid_d;

  logic             s_bit, c_bit;
  logic [WIDTH-1:0] sum_shift;

  // The single full-adder cell.
  assign s_bit = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
  assign c_bit = (a_sr_q[0] & b_sr_q[0]) | ((a_sr_q[0] ^ b_sr_q[0]) & carry_q);

  // Result bits enter at the MSB so the first (LSB) bit lands at position 0.
  generate
    if (WIDTH == 1) begin : g_w1
      assign sum_shift = s_bit;
    end else begin : g_wn
      assign sum_shift = {s_bit, sum_sr_q[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    a_sr_d      = a_sr_q;
    b_sr_d      = b_sr_q;
    sum_sr_d    = sum_sr_q;
    sum_d       = sum_q;
    count_d     = count_q;
    carry_d     = carry_q;
    cout_d      = cout_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sr_d  = a;
          b_sr_d  = b;
          carry_d = cin;
          count_d = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        sum_sr_d = sum_shift;
        carry_d  = c_bit;
        count_d  = count_q + CW'(1);
        if (count_q == CW'(WIDTH - 1)) begin
          sum_d       = sum_shift;
          cout_d      = c_bit;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_sr_q      <= '0;
      b_sr_q      <= '0;
      sum_sr_q    <= '0;
      sum_q       <= '0;
      count_q     <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sr_q      <= a_sr_d;
      b_sr_q      <= b_sr_d;
      sum_sr_q    <= sum_sr_d;
      sum_q       <= sum_d;
      count_q     <= count_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule
